// File: rtl/priority_event_encoder_pkg.sv
// Shared encoder/decoder definitions: output-slot state encoding and lowest-set-bit search.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package priority_event_encoder_pkg;

  // Widest request vector any library encoder is built for
  localparam int MAX_N = 32;

  // Output slot is either empty or holding an event for the consumer
  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } enc_state_t;

  // Index of the lowest set bit, 0 when the vector is all zero
  function automatic int lowest_set_index(input logic [MAX_N-1:0] vec);
    lowest_set_index = 0;
    for (int i = MAX_N - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set_index = i;
    end
  endfunction

endpackage

// File: rtl/priority_encoder_comb.sv
// Combinational N-to-W lowest-index encoder with a found flag.
// Latency: zero cycles, purely combinational.
// Backpressure: none; output follows the input vector every cycle.
module priority_encoder_comb
  import priority_event_encoder_pkg::*;
#(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [MAX_N-1:0] vec_ext;

  // Zero-extend to the package width and pick the lowest set index
  always_comb begin
    vec_ext        = '0;
    vec_ext[N-1:0] = vec;
    idx            = W'(lowest_set_index(vec_ext));
    found          = |vec;
  end

endmodule

// File: rtl/priority_event_encoder.sv
// Sticky event capture with lowest-index-first emission through a one-entry output slot.
// Latency: one cycle from req to code/valid when the slot is free; one event per cycle sustained.
// Backpressure: valid && !ready freezes code/valid; new events accumulate in pending.
// Optional macro PRIORITY_EVENT_ENCODER_OVF_EN adds the sticky ovf lost-event flag.
module priority_event_encoder
  import priority_event_encoder_pkg::*;
#(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [W-1:0] code,
  output logic         valid,
  input  logic         ready,
  output logic [N-1:0] pending
`ifdef PRIORITY_EVENT_ENCODER_OVF_EN
  ,
  output logic         ovf
`endif
);

  enc_state_t   state;
  enc_state_t   state_nxt;
  logic [N-1:0] req_en;
  logic [N-1:0] cand;
  logic [N-1:0] sel;
  logic [N-1:0] pending_nxt;
  logic [W-1:0] idx;
  logic         found;
  logic         slot_free;
  logic         load;

  assign req_en    = en ? req : '0;
  assign cand      = pending | req_en;
  assign slot_free = (state == EMPTY) || ready;
  assign load      = slot_free && found;
  assign sel       = load ? (N'(1) << idx) : '0;

  // A selected bit leaves pending; a re-request landing on an already
  // pending bit being emitted is a fresh event and keeps the bit set.
  // A request that is itself the selected candidate goes straight out.
  assign pending_nxt = (cand & ~sel) | (req_en & pending & sel);

  priority_encoder_comb #(.N(N)) u_enc (
    .vec   (cand),
    .idx   (idx),
    .found (found)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // Next state: fill on any candidate, drain on accept with nothing left
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (found) state_nxt = HOLD;
      HOLD:    if (ready && !found) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Output decode: slot occupancy is the registered state
  always_comb begin
    valid = (state == HOLD);
  end

  // Code and pending registers; code holds its value when nothing loads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code    <= '0;
      pending <= '0;
    end else begin
      if (load) code <= idx;
      pending <= pending_nxt;
    end
  end

`ifdef PRIORITY_EVENT_ENCODER_OVF_EN
  // Sticky lost-event flag: request hits a pending bit that is not leaving
  always_ff @(posedge clk) begin
    if (!rst_n)                           ovf <= 1'b0;
    else if (|(req_en & pending & ~sel))  ovf <= 1'b1;
  end
`endif

endmodule

// File: doc/priority_event_encoder.md
PRIORITY_EVENT_ENCODER -- requirements
Module: priority_event_encoder

Interface
REQ-001 SHALL have parameter N, default 8: number of request lines, 2..32.
REQ-002 SHALL have localparam W = $clog2(N): width of the index code.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port en, input, 1: capture enable for req; draining continues when low.
REQ-006 SHALL have port req, input, N: event request lines, sampled each clock.
REQ-007 SHALL have port code, output, W: binary index of the emitted event; registered.
REQ-008 SHALL have port valid, output, 1: code holds an event; registered.
REQ-009 SHALL have port ready, input, 1: consumer accepts code when valid && ready.
REQ-010 SHALL have port pending, output, N: sticky captured-but-not-emitted events; registered.
REQ-011 SHALL have port ovf, output, 1: sticky overflow flag; present only under the macro in REQ-030.

Function
REQ-012 SHALL capture: when en=1, each req[i]=1 at a clock edge sets pending[i]; when en=0, req is ignored.
REQ-013 SHALL define the candidate set as pending | (en ? req : 0), evaluated in the current cycle.
REQ-014 SHALL define the output slot as free when valid=0, or when valid=1 && ready=1.
REQ-015 SHALL load the output when the slot is free and the candidate set is non-zero: code = lowest set index, valid=1, and that bit cleared from pending.
REQ-016 SHALL load nothing when the slot is free and the candidate set is zero: valid=0 next cycle, code holds its last value.
REQ-017 SHALL hold code and valid stable while valid=1 && ready=0; no candidate may overtake.
REQ-018 SHALL keep latency at one cycle: req[i] high at edge t with the slot free and no lower candidate gives valid=1, code=i after edge t.
REQ-019 SHALL sustain throughput of one event per cycle with ready held at 1.
REQ-020 SHALL resolve simultaneous set and clear: if req[i]=1 and en=1 in the cycle that bit i is selected for emission, pending[i] stays 1 (new event), and that event is emitted later.
REQ-021 SHALL merge re-requests: req[i] while pending[i]=1 does not queue a second event for i.
REQ-022 SHALL behave as two states: EMPTY (valid=0) and HOLD (valid=1).
REQ-023 SHALL transition EMPTY->HOLD on a non-zero candidate set; HOLD->EMPTY on accept with an empty candidate set; HOLD->HOLD on accept with a non-empty set (reload) or when not accepted.
REQ-024 SHALL allow ready to be asserted while valid=0 with no effect.

Reset
REQ-025 SHALL, when rst_n=0 at a clock edge, set valid=0, code=0, pending=0 and ovf=0 (if present).
REQ-026 SHALL let reset dominate all other inputs, including mid-HOLD; an event held in code at reset is discarded.
REQ-027 SHALL not capture req in the reset cycle; capture resumes at the first edge with rst_n=1.

Configuration
REQ-028 SHALL use the macro PRIORITY_EVENT_ENCODER_OVF_EN.
REQ-029 SHALL, with the macro undefined, omit the ovf port and its logic entirely.
REQ-030 SHALL, with the macro defined, set ovf=1 when req[i]=1 and en=1 while pending[i]=1 is already set and not being cleared this cycle (lost event).
REQ-031 SHALL hold ovf sticky until rst_n=0.

Structure
REQ-032 SHALL place the state encoding (EMPTY, HOLD) and a lowest-set-bit index function in the shared package used by the library encoders and decoders.
REQ-033 SHALL use one sub-module, priority_encoder_comb: a combinational N-to-W lowest-index encoder with a found flag, instantiated once on the candidate set.

Verification
REQ-034 SHALL run a reset scenario: drive req=8'hFF with rst_n=0 for 2 cycles, then release with req=0 -> valid=0, pending=0, ovf=0 during reset and 1 cycle after.
REQ-035 SHALL run a single-event scenario: req=8'h20 for 1 cycle, ready=1 -> next cycle valid=1, code=5, then valid=0.
REQ-036 SHALL run a priority-drain scenario: req=8'hA4 for 1 cycle, ready=1 -> code=2,5,7 on consecutive cycles, then valid=0, pending=0.
REQ-037 SHALL run a backpressure scenario: ready=0 with req=8'h03 -> code=0 held with valid=1 for 5 cycles and pending=8'h02; raise ready -> code=1 next cycle.
REQ-038 SHALL run a set/clear collision scenario: hold req[3] high 3 cycles with ready=1 -> code=3 emitted each cycle, no event lost, no ovf.
REQ-039 SHALL run an overflow scenario (macro on): ready=0, req=8'h01 then req=8'h02 twice -> ovf=1 after the third edge and stays 1 until reset; with the macro off, the design compiles without an ovf port.
